// File: rtl/reg_wb_pkg.sv
// Shared widths and the queued writeback entry type for the register writeback queue.
package reg_wb_pkg;
  localparam int REG_ID_W = 4;
  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 16;

  typedef struct packed {
    logic [REG_ID_W-1:0] rid;
    logic [DATA_W-1:0]   data;
  } wb_entry_t;
endpackage

// File: rtl/wb_match.sv
// Youngest-match search over the live FIFO entries for one register read port.
module wb_match
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  wb_entry_t [DEPTH-1:0] entries,
  input  logic [PTR_W-1:0]      head,
  input  logic [CNT_W-1:0]      count,
  input  logic [REG_ID_W-1:0]   lookup_reg,
  output logic                  hit,
  output logic [DATA_W-1:0]     data
);
  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (CNT_W'(k) < count && entries[idx].rid == lookup_reg) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end
endmodule

// File: rtl/reg_writeback_queue.sv
// Circular FIFO buffering register-file writebacks while the write port is busy.
// Define WB_QUEUE_BYPASS_EN to add two forwarding lookup ports (youngest match).
module reg_writeback_queue
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_valid,
  input  logic [REG_ID_W-1:0] wb_reg,
  input  logic [DATA_W-1:0]   wb_data,
  output logic                wb_ready,
  input  logic                rf_stall,
  output logic                WriteReg,
  output logic [REG_ID_W-1:0] DstReg,
  output logic [DATA_W-1:0]   DstData,
  output logic [NUM_REGS-1:0] pending
`ifdef WB_QUEUE_BYPASS_EN
  ,
  input  logic [REG_ID_W-1:0] lookup1_reg,
  input  logic [REG_ID_W-1:0] lookup2_reg,
  output logic                lookup1_hit,
  output logic                lookup2_hit,
  output logic [DATA_W-1:0]   lookup1_data,
  output logic [DATA_W-1:0]   lookup2_data
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DEPTH-1:0]      live;
  logic                  push, pop;

  assign wb_ready = (count_q < CNT_W'(DEPTH)) && !rst;
  assign WriteReg = (count_q != '0) && !rf_stall && !rst;
  assign push     = wb_valid && wb_ready;
  assign pop      = WriteReg;
  assign DstReg   = (count_q != '0) ? mem_q[head_q].rid  : '0;
  assign DstData  = (count_q != '0) ? mem_q[head_q].data : '0;

  // A slot is live when its distance from head is below the occupancy.
  for (genvar i = 0; i < DEPTH; i++) begin : g_live
    logic [PTR_W-1:0] age;
    assign age     = PTR_W'(i) - head_q;
    assign live[i] = CNT_W'(age) < count_q;
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++)
      if (live[i]) pending[mem_q[i].rid] = 1'b1;
  end

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      mem_d[tail_q] = '{rid: wb_reg, data: wb_data};
      tail_d        = tail_q + 1'b1;
    end
    if (pop) head_d = head_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

`ifdef WB_QUEUE_BYPASS_EN
  wb_match #(.DEPTH(DEPTH)) u_match1 (
    .entries(mem_q), .head(head_q), .count(count_q),
    .lookup_reg(lookup1_reg), .hit(lookup1_hit), .data(lookup1_data)
  );
  wb_match #(.DEPTH(DEPTH)) u_match2 (
    .entries(mem_q), .head(head_q), .count(count_q),
    .lookup_reg(lookup2_reg), .hit(lookup2_hit), .data(lookup2_data)
  );
`endif
endmodule

// File: tb/tb_reg_writeback_queue.sv
// Randomized and directed bench for reg_writeback_queue against a queue-based reference model.
module tb_reg_writeback_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, wb_valid, wb_ready, rf_stall, WriteReg;
  logic [3:0]  wb_reg, DstReg;
  logic [15:0] wb_data, DstData, pending;
  logic [3:0]  lookup1_reg, lookup2_reg;
  logic        lookup1_hit, lookup2_hit;
  logic [15:0] lookup1_data, lookup2_data;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct { logic [3:0] r; logic [15:0] d; } ent_t;
  ent_t mq[$];

  always #5 clk = ~clk;

  reg_writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .wb_ready(wb_ready), .rf_stall(rf_stall), .WriteReg(WriteReg), .DstReg(DstReg),
    .DstData(DstData), .pending(pending)
`ifdef WB_QUEUE_BYPASS_EN
    , .lookup1_reg(lookup1_reg), .lookup2_reg(lookup2_reg),
    .lookup1_hit(lookup1_hit), .lookup2_hit(lookup2_hit),
    .lookup1_data(lookup1_data), .lookup2_data(lookup2_data)
`endif
  );

`ifndef WB_QUEUE_BYPASS_EN
  assign lookup1_hit = 1'b0;
  assign lookup2_hit = 1'b0;
  assign lookup1_data = '0;
  assign lookup2_data = '0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit m_ready();
    return mq.size() < DEPTH && !rst;
  endfunction

  function automatic bit m_write();
    return mq.size() != 0 && !rf_stall && !rst;
  endfunction

  function automatic logic [15:0] m_pending();
    logic [15:0] p = '0;
    foreach (mq[i]) p[mq[i].r] = 1'b1;
    return p;
  endfunction

  function automatic logic [16:0] m_lookup(input logic [3:0] r);
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].r == r) return {1'b1, mq[i].d};
    return '0;
  endfunction

  task automatic drive(input bit v, input logic [3:0] r, input logic [15:0] d,
                       input bit stall, input bit rs);
    wb_valid = v; wb_reg = r; wb_data = d; rf_stall = stall; rst = rs;
    lookup1_reg = 4'($urandom_range(0, 15));
    lookup2_reg = 4'($urandom_range(0, 15));
  endtask

  // Called mid-cycle: compare every output against the model.
  task automatic sample();
    logic [16:0] l;
    #4;
    chk("wb_ready", wb_ready, m_ready());
    chk("WriteReg", WriteReg, m_write());
    chk("DstReg", DstReg, mq.size() ? mq[0].r : 4'h0);
    chk("DstData", DstData, mq.size() ? mq[0].d : 16'h0);
    chk("pending", pending, m_pending());
`ifdef WB_QUEUE_BYPASS_EN
    l = m_lookup(lookup1_reg);
    chk("lookup1_hit", lookup1_hit, l[16]);
    chk("lookup1_data", lookup1_data, l[15:0]);
    l = m_lookup(lookup2_reg);
    chk("lookup2_hit", lookup2_hit, l[16]);
    chk("lookup2_data", lookup2_data, l[15:0]);
`else
    l = '0;
`endif
  endtask

  task automatic tick();
    bit w, a;
    @(posedge clk);
    w = m_write();
    a = wb_valid && m_ready();
    if (rst) mq.delete();
    else begin
      if (w) void'(mq.pop_front());
      if (a) mq.push_back('{wb_reg, wb_data});
    end
    #1;
  endtask

  task automatic step(input bit v, input logic [3:0] r, input logic [15:0] d,
                      input bit stall, input bit rs);
    drive(v, r, d, stall, rs);
    sample();
    tick();
  endtask

  initial begin
    drive(0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 1);
    sample();
    tick();
    // Post-reset idle state.
    drive(0, 0, 0, 0, 0);
    sample();
    chk("rst_ready", wb_ready, 1);
    chk("rst_write", WriteReg, 0);
    chk("rst_pending", pending, 0);
    tick();

    // Single push, written the next cycle.
    step(1, 4'd3, 16'h1234, 0, 0);
    drive(0, 0, 0, 0, 0);
    sample();
    chk("one_write", WriteReg, 1);
    chk("one_reg", DstReg, 3);
    chk("one_data", DstData, 16'h1234);
    chk("one_pend", pending, 16'h0008);
    tick();
    drive(0, 0, 0, 0, 0);
    sample();
    chk("one_after_write", WriteReg, 0);
    chk("one_after_pend", pending, 0);
    tick();

    // Fill under stall, refuse fifth offer, drain in order.
    for (int i = 1; i <= 4; i++) step(1, 4'(i), 16'(16'h100 * i), 1, 0);
    drive(1, 4'd9, 16'h9999, 1, 0);
    sample();
    chk("full_ready", wb_ready, 0);
    chk("full_pend", pending, 16'h001E);
    tick();
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 0, 0, 0);
      sample();
      chk("drain_write", WriteReg, 1);
      chk("drain_reg", DstReg, 4'(i));
      tick();
    end

    // Full with pop: no pass-through, accepted on the next cycle.
    for (int i = 0; i < 4; i++) step(1, 4'(i + 8), 16'(16'hA0 + i), 1, 0);
    drive(1, 4'd7, 16'h7777, 0, 0);
    sample();
    chk("nopass_ready", wb_ready, 0);
    chk("nopass_write", WriteReg, 1);
    tick();
    drive(1, 4'd7, 16'h7777, 0, 0);
    sample();
    chk("next_ready", wb_ready, 1);
    tick();
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);

`ifdef WB_QUEUE_BYPASS_EN
    // Youngest match forwarding.
    step(1, 4'd5, 16'hAAAA, 1, 0);
    step(1, 4'd5, 16'hBBBB, 1, 0);
    drive(0, 0, 0, 1, 0);
    lookup1_reg = 4'd5;
    lookup2_reg = 4'd6;
    sample();
    chk("byp_hit1", lookup1_hit, 1);
    chk("byp_data1", lookup1_data, 16'hBBBB);
    chk("byp_hit2", lookup2_hit, 0);
    chk("byp_data2", lookup2_data, 0);
    tick();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
`endif

    // Reset mid-operation discards entries and blocks the write.
    for (int i = 0; i < 3; i++) step(1, 4'(i + 2), 16'(16'h500 + i), 1, 0);
    drive(0, 0, 0, 0, 1);
    sample();
    chk("midrst_write", WriteReg, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0);
      sample();
      chk("postrst_write", WriteReg, 0);
      chk("postrst_pend", pending, 0);
      chk("postrst_ready", wb_ready, 1);
      tick();
    end

    // Random traffic with small register range to exercise duplicates.
    for (int c = 0; c < 400; c++)
      step($urandom_range(0, 9) < 6, 4'($urandom_range(0, 5)), 16'($urandom),
           $urandom_range(0, 9) < 4, $urandom_range(0, 59) == 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
